// File: rtl/bomb_module_pkg.sv
// Shared arena geometry and bomb FSM state encoding.
package bomb_module_pkg;

  // Arena placement on screen and tile grid
  localparam int unsigned X_WALL_L = 48;
  localparam int unsigned Y_WALL_U = 31;
  localparam int unsigned TILE     = 16;
  localparam int unsigned ARENA_W  = 33;
  localparam int unsigned ARENA_H  = 27;

  localparam int unsigned ABM_W    = 6;
  localparam int unsigned PIX_W    = 11;

  // Bomb FSM states
  localparam int unsigned STATE_W  = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FUSE   = 3'd1;
  localparam logic [2:0] ST_CALC   = 3'd2;
  localparam logic [2:0] ST_EXP    = 3'd3;
  localparam logic [2:0] ST_POST   = 3'd4;

endpackage

// File: rtl/bomb_module_pixel_to_abm.sv
// Screen pixel to arena tile conversion with an inside-arena flag.
module pixel_to_abm
  import bomb_module_pkg::*;
(
  input  logic [PIX_W-1:0] px,
  input  logic [PIX_W-1:0] py,
  output logic [ABM_W-1:0] tx,
  output logic [ABM_W-1:0] ty,
  output logic             valid
);

  logic [PIX_W-1:0] px_off;
  logic [PIX_W-1:0] py_off;

  // Offset from the arena corner, then divide by the 16 px tile size
  always_comb begin
    px_off = px - PIX_W'(X_WALL_L);
    py_off = py - PIX_W'(Y_WALL_U);
    tx     = ABM_W'(px_off >> 4);
    ty     = ABM_W'(py_off >> 4);
    valid  = (px >= PIX_W'(X_WALL_L)) && (px < PIX_W'(X_WALL_L + TILE * ARENA_W)) &&
             (py >= PIX_W'(Y_WALL_U)) && (py < PIX_W'(Y_WALL_U + TILE * ARENA_H));
  end

endmodule

// File: rtl/bomb_module.sv
// Single bomb: fuse, blast-arm calculation, explosion display, cooldown.
module bomb_module
  import bomb_module_pkg::*;
#(
  parameter int unsigned FUSE_CYCLES = 150000000,
  parameter int unsigned EXP_CYCLES  = 50000000,
  parameter int unsigned POST_CYCLES = 25000000,
  parameter int unsigned EXP_RANGE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] x_b,
  input  logic [9:0] y_b,
  input  logic       place_bomb,
  output logic       bomb_on,
  output logic       exp_on,
  output logic       post_exp_active,
  output logic       bomb_active,
  output logic       bomb_frame
);

  localparam int unsigned CNT_W = 32;

  logic [STATE_W-1:0] state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ABM_W-1:0]   bx, by;
  logic [ABM_W-1:0]   ptx, pty, btx, bty;
  logic               pix_valid, bman_valid;
  logic [3:0][1:0]    arm;       // 0 up, 1 right, 2 down, 3 left
  logic [3:0]         blocked;
  logic [1:0]         calc_dir;
  logic [1:0]         calc_step;
  logic [7:0]         cand_x, cand_y;
  logic               cand_ok, calc_last;
  logic [7:0]         ptx8, pty8, bx8, by8;
  logic               row_hit, col_hit;

  pixel_to_abm u_pix (
    .px    ({1'b0, x}),
    .py    ({1'b0, y}),
    .tx    (ptx),
    .ty    (pty),
    .valid (pix_valid)
  );

  // Bomberman's sprite centre decides which tile receives the bomb
  pixel_to_abm u_bman (
    .px    (PIX_W'(x_b) + PIX_W'(8)),
    .py    (PIX_W'(y_b) + PIX_W'(8)),
    .tx    (btx),
    .ty    (bty),
    .valid (bman_valid)
  );

  // Next state and phase counter; the counter restarts on every state change
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    case (state)
      ST_IDLE: if (place_bomb && bman_valid) state_next = ST_FUSE;
      ST_FUSE: if (cnt == CNT_W'(FUSE_CYCLES - 1)) state_next = ST_CALC;
      ST_CALC: if (calc_last) state_next = ST_EXP;
      ST_EXP:  if (cnt == CNT_W'(EXP_CYCLES - 1)) state_next = ST_POST;
      ST_POST: if (cnt == CNT_W'(POST_CYCLES - 1)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (state_next != state || state == ST_IDLE) cnt_next = '0;
  end

  // State and phase counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Bomb tile latched when a bomb is dropped from idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx <= '0;
      by <= '0;
    end else if (state == ST_IDLE && state_next == ST_FUSE) begin
      bx <= btx;
      by <= bty;
    end
  end

  // Candidate tile for the current direction/step, checked against walls and pillars
  always_comb begin
    cand_x = {2'b00, bx};
    cand_y = {2'b00, by};
    case (calc_dir)
      2'd0:    cand_y = {2'b00, by} - {6'b0, calc_step};
      2'd1:    cand_x = {2'b00, bx} + {6'b0, calc_step};
      2'd2:    cand_y = {2'b00, by} + {6'b0, calc_step};
      default: cand_x = {2'b00, bx} - {6'b0, calc_step};
    endcase
    cand_ok   = (cand_x < 8'(ARENA_W)) && (cand_y < 8'(ARENA_H)) && !(cand_x[0] && cand_y[0]);
    calc_last = (calc_dir == 2'd3) && (calc_step == 2'(EXP_RANGE));
  end

  // Arm lengths grow one step per cycle until a direction hits an obstacle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm       <= '0;
      blocked   <= '0;
      calc_dir  <= 2'd0;
      calc_step <= 2'd1;
    end else if (state == ST_FUSE && state_next == ST_CALC) begin
      arm       <= '0;
      blocked   <= '0;
      calc_dir  <= 2'd0;
      calc_step <= 2'd1;
    end else if (state == ST_CALC) begin
      if (!blocked[calc_dir]) begin
        if (cand_ok) arm[calc_dir] <= calc_step;
        else         blocked[calc_dir] <= 1'b1;
      end
      if (calc_step == 2'(EXP_RANGE)) begin
        calc_step <= 2'd1;
        calc_dir  <= calc_dir + 2'd1;
      end else begin
        calc_step <= calc_step + 2'd1;
      end
    end
  end

  // Pixel hit tests; ranges rearranged as additions so edge tiles never wrap
  always_comb begin
    ptx8    = {2'b00, ptx};
    pty8    = {2'b00, pty};
    bx8     = {2'b00, bx};
    by8     = {2'b00, by};
    row_hit = (pty == by) && (ptx8 + {6'b0, arm[3]} >= bx8) && (ptx8 <= bx8 + {6'b0, arm[1]});
    col_hit = (ptx == bx) && (pty8 + {6'b0, arm[0]} >= by8) && (pty8 <= by8 + {6'b0, arm[2]});
    bomb_on         = (state == ST_FUSE) && pix_valid && (ptx == bx) && (pty == by);
    exp_on          = (state == ST_EXP) && pix_valid && (row_hit || col_hit);
    post_exp_active = (state == ST_EXP) || (state == ST_POST);
    bomb_active     = (state != ST_IDLE);
    bomb_frame      = (state == ST_FUSE) && cnt[23];
  end

endmodule

// File: tb/tb_bomb_module.sv
// Directed bench for bomb_module with shortened fuse/explosion timings.
module tb_bomb_module;

  logic       clk;
  logic       reset;
  logic [9:0] x, y, x_b, y_b;
  logic       place_bomb;
  logic       bomb_on, exp_on, post_exp_active, bomb_active, bomb_frame;

  int checks = 0;
  int errors = 0;

  bomb_module #(
    .FUSE_CYCLES (100),
    .EXP_CYCLES  (50),
    .POST_CYCLES (20),
    .EXP_RANGE   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .x               (x),
    .y               (y),
    .x_b             (x_b),
    .y_b             (y_b),
    .place_bomb      (place_bomb),
    .bomb_on         (bomb_on),
    .exp_on          (exp_on),
    .post_exp_active (post_exp_active),
    .bomb_active     (bomb_active),
    .bomb_frame      (bomb_frame)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Point the pixel at the centre of a tile and let the combinational outputs settle
  task automatic probe_tile(input int tx, input int ty);
    x = 10'(48 + 16 * tx + 8);
    y = 10'(31 + 16 * ty + 8);
    #1;
  endtask

  task automatic probe_px(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    #1;
  endtask

  int n, pa, ea;

  initial begin
    reset = 1'b1; place_bomb = 1'b0;
    x = '0; y = '0; x_b = 10'd208; y_b = 10'd191;
    tick(); tick();
    check("rst_active", 32'(bomb_active), 0);
    check("rst_post",   32'(post_exp_active), 0);
    reset = 1'b0;
    tick();
    check("idle_active", 32'(bomb_active), 0);

    // Bomb at tile (10,10), single-cycle request
    probe_px(216, 199);
    check("idle_bomb_on", 32'(bomb_on), 0);
    place_bomb = 1'b1;
    tick();
    place_bomb = 1'b0;
    check("fuse_active", 32'(bomb_active), 1);
    check("fuse_frame",  32'(bomb_frame), 0);
    n = 0;
    while (bomb_on && n < 300) begin n++; tick(); end
    check("fuse_len", 32'(n), 100);
    check("calc_active", 32'(bomb_active), 1);
    n = 0;
    while (!post_exp_active && n < 30) begin n++; tick(); end
    check("calc_len", 32'(n), 8);

    probe_tile(8, 10);  check("exp_l2", 32'(exp_on), 1);
    probe_tile(7, 10);  check("exp_l3", 32'(exp_on), 0);
    probe_tile(12, 10); check("exp_r2", 32'(exp_on), 1);
    probe_tile(13, 10); check("exp_r3", 32'(exp_on), 0);
    probe_tile(10, 8);  check("exp_u2", 32'(exp_on), 1);
    probe_tile(10, 12); check("exp_d2", 32'(exp_on), 1);
    probe_tile(10, 13); check("exp_d3", 32'(exp_on), 0);
    probe_tile(11, 11); check("exp_diag", 32'(exp_on), 0);
    probe_tile(10, 10); check("exp_centre", 32'(exp_on), 1);
    check("exp_bomb_on", 32'(bomb_on), 0);

    pa = 0; ea = 0;
    while (post_exp_active && pa < 300) begin
      pa++;
      if (exp_on) ea++;
      tick();
    end
    check("post_len", 32'(pa), 70);
    check("exp_len",  32'(ea), 50);
    check("back_idle", 32'(bomb_active), 0);

    // Request held high: re-arm only after one idle cycle
    place_bomb = 1'b1;
    tick();
    n = 0;
    while (bomb_active && n < 400) begin n++; tick(); end
    check("held_cycle_len", 32'(n), 178);
    check("held_idle_gap", 32'(bomb_active), 0);
    tick();
    check("held_rearm", 32'(bomb_active), 1);
    place_bomb = 1'b0;

    // Reset in the middle of the explosion
    n = 0;
    while (!post_exp_active && n < 200) begin n++; tick(); end
    tick(); tick();
    probe_tile(10, 10);
    check("pre_rst_exp", 32'(exp_on), 1);
    reset = 1'b1;
    #1;
    check("rst_exp_on",  32'(exp_on), 0);
    check("rst_post_on", 32'(post_exp_active), 0);
    check("rst_act_on",  32'(bomb_active), 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("after_rst_idle", 32'(bomb_active), 0);

    // Bomb at tile (0,1): pillar at (1,1), wall to the left
    x_b = 10'd40; y_b = 10'd39;
    probe_tile(0, 1);
    place_bomb = 1'b1;
    tick();
    place_bomb = 1'b0;
    n = 0;
    while (bomb_on && n < 300) begin n++; tick(); end
    check("edge_fuse_len", 32'(n), 100);
    n = 0;
    while (!post_exp_active && n < 30) begin n++; tick(); end
    probe_tile(0, 1); check("edge_centre", 32'(exp_on), 1);
    probe_tile(0, 0); check("edge_up",     32'(exp_on), 1);
    probe_tile(1, 1); check("edge_pillar", 32'(exp_on), 0);
    probe_tile(0, 2); check("edge_down",   32'(exp_on), 1);
    probe_px(40, 55); check("edge_left_px", 32'(exp_on), 0);
    probe_px(47, 55); check("edge_wall_px", 32'(exp_on), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
